// File: rtl/parity_frame_checker.sv
// Serial LSB-first frame receiver with trailing parity bit. It reassembles each data word,
// flags parity errors and keeps a saturating count of the frames that failed parity.
module parity_frame_checker #(
    parameter int DATA_BITS  = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 clear,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 out_valid,
    output logic                 parity_err,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int CNT_W = $clog2(DATA_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);
    localparam logic ODD_BIT = (ODD_PARITY != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t                 state_r, state_s;
    logic [DATA_BITS-1:0]   sh_r, sh_s;
    logic                   acc_r, acc_s;
    logic [CNT_W-1:0]       cnt_r, cnt_s;
    logic [DATA_BITS-1:0]   data_r, data_s;
    logic                   valid_r, valid_s;
    logic                   perr_r, perr_s;
    logic [7:0]             errc_r, errc_s;
    logic                   fail_s;

    // An error is any mismatch between the running XOR and the selected parity sense.
    function automatic logic parity_fail(input logic acc, input logic par, input logic odd);
        return (acc ^ par) != odd;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        if (v == 8'hFF) begin
            return v;
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic [DATA_BITS-1:0] put_bit(input logic [DATA_BITS-1:0] v,
                                                     input logic [CNT_W-1:0]     idx,
                                                     input logic                 b);
        logic [DATA_BITS-1:0] r;
        r = v;
        for (int i = 0; i < DATA_BITS; i++) begin
            if (CNT_W'(i) == idx) begin
                r[i] = b;
            end else begin
                r[i] = v[i];
            end
        end
        return r;
    endfunction

    // Next-state and next-output decode; clear beats an incoming bit.
    always_comb begin
        state_s = state_r;
        sh_s    = sh_r;
        acc_s   = acc_r;
        cnt_s   = cnt_r;
        data_s  = data_r;
        valid_s = 1'b0;
        perr_s  = perr_r;
        errc_s  = errc_r;
        fail_s  = parity_fail(acc_r, bit_in, ODD_BIT);
        if (clear) begin
            state_s = IDLE;
            cnt_s   = '0;
            acc_s   = 1'b0;
        end else if (bit_valid) begin
            case (state_r)
                IDLE: begin
                    sh_s    = put_bit(sh_r, '0, bit_in);
                    acc_s   = bit_in;
                    cnt_s   = CNT_W'(1);
                    state_s = DATA;
                end
                DATA: begin
                    sh_s  = put_bit(sh_r, cnt_r, bit_in);
                    acc_s = acc_r ^ bit_in;
                    cnt_s = cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_IDX) begin
                        state_s = PARITY;
                    end else begin
                        state_s = DATA;
                    end
                end
                PARITY: begin
                    data_s  = sh_r;
                    perr_s  = fail_s;
                    valid_s = 1'b1;
                    if (fail_s) begin
                        errc_s = sat_inc(errc_r);
                    end else begin
                        errc_s = errc_r;
                    end
                    cnt_s   = '0;
                    acc_s   = 1'b0;
                    state_s = IDLE;
                end
                default: begin
                    // Unreachable encoding: recover to a clean idle frame boundary.
                    state_s = IDLE;
                    cnt_s   = '0;
                    acc_s   = 1'b0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sh_r    <= '0;
            acc_r   <= 1'b0;
            cnt_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            errc_r  <= 8'd0;
        end else begin
            state_r <= state_s;
            sh_r    <= sh_s;
            acc_r   <= acc_s;
            cnt_r   <= cnt_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            perr_r  <= perr_s;
            errc_r  <= errc_s;
        end
    end

    assign data_out   = data_r;
    assign out_valid  = valid_r;
    assign parity_err = perr_r;
    assign err_count  = errc_r;
    assign busy       = (state_r != IDLE);

endmodule

// File: tb/tb_parity_frame_checker.sv
// Scoreboard bench: an even-parity and an odd-parity instance share one input stream;
// expected frame results are queued as parity bits are driven and checked on out_valid.
module tb_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       clear;
    logic [7:0] data_e, data_o;
    logic       ov_e, ov_o, perr_e, perr_o, busy_e, busy_o;
    logic [7:0] errc_e, errc_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic [7:0] errc;
    } exp_t;

    exp_t q_e[$];
    exp_t q_o[$];
    int   model_cnt_e = 0, model_cnt_o = 0;
    int   pushed = 0, pulses_e = 0, pulses_o = 0;
    logic [7:0] last_data = 8'h00;

    parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .data_out(data_e), .out_valid(ov_e), .parity_err(perr_e), .busy(busy_e),
        .err_count(errc_e)
    );

    parity_frame_checker #(.DATA_BITS(8), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .clear(clear),
        .data_out(data_o), .out_valid(ov_o), .parity_err(perr_o), .busy(busy_o),
        .err_count(errc_o)
    );

    always #5 clk = ~clk;

    task check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (ov_e) begin
            pulses_e++;
            if (q_e.size() == 0) begin
                check_val("even_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_e.pop_front();
                check_val("even_data", {24'd0, data_e}, {24'd0, e.data});
                check_val("even_perr", {31'd0, perr_e}, {31'd0, e.perr});
                check_val("even_errc", {24'd0, errc_e}, {24'd0, e.errc});
            end
        end
        if (ov_o) begin
            pulses_o++;
            if (q_o.size() == 0) begin
                check_val("odd_unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q_o.pop_front();
                check_val("odd_data", {24'd0, data_o}, {24'd0, e.data});
                check_val("odd_perr", {31'd0, perr_o}, {31'd0, e.perr});
                check_val("odd_errc", {24'd0, errc_o}, {24'd0, e.errc});
            end
        end
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task gap(input int max_gap);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
        repeat (g) tick();
    endtask

    task send_frame(input logic [7:0] d, input logic p, input int max_gap, input bit chk_busy);
        exp_t e;
        logic x_even, x_odd;
        for (int i = 0; i < 8; i++) begin
            gap(max_gap);
            send_bit(d[i]);
            if (chk_busy) check_val("busy_data", {31'd0, busy_e}, 32'd1);
        end
        gap(max_gap);
        send_bit(p);
        if (chk_busy) check_val("busy_after_parity", {31'd0, busy_e}, 32'd0);
        x_even = ((^d) ^ p) != 1'b0;
        x_odd  = ((^d) ^ p) != 1'b1;
        if (x_even && model_cnt_e < 255) model_cnt_e++;
        if (x_odd && model_cnt_o < 255) model_cnt_o++;
        e.data = d; e.perr = x_even; e.errc = 8'(model_cnt_e);
        q_e.push_back(e);
        e.perr = x_odd; e.errc = 8'(model_cnt_o);
        q_o.push_back(e);
        pushed++;
        last_data = d;
    endtask

    initial begin
        int base_e;
        rst = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; clear = 1'b0;
        repeat (3) tick();
        check_val("rst_data", {24'd0, data_e}, 32'd0);
        check_val("rst_valid", {31'd0, ov_e}, 32'd0);
        check_val("rst_perr", {31'd0, perr_e}, 32'd0);
        check_val("rst_busy", {31'd0, busy_e}, 32'd0);
        check_val("rst_errc", {24'd0, errc_e}, 32'd0);
        rst = 1'b0;
        tick();

        // Clean frame, continuous bits, with busy tracked bit by bit.
        send_frame(8'hA5, 1'b0, 0, 1'b1);
        check_val("a5_valid_pulse", {31'd0, ov_e}, 32'd1);
        tick();
        check_val("a5_valid_one_cycle", {31'd0, ov_e}, 32'd0);

        // Error frame followed by its corrected twin.
        send_frame(8'h07, 1'b0, 0, 1'b0);
        send_frame(8'h07, 1'b1, 0, 1'b0);
        tick();
        check_val("errc_after_07", {24'd0, errc_e}, 32'd1);

        // Gapped delivery must decode the same as back-to-back.
        base_e = pulses_e;
        send_frame(8'h3C, 1'b0, 5, 1'b0);
        repeat (3) tick();
        check_val("gapped_pulses", pulses_e - base_e, 32'd1);

        // Abort mid-frame: clear wins over a simultaneous bit.
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        clear = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
        tick();
        clear = 1'b0; bit_valid = 1'b0;
        check_val("abort_busy", {31'd0, busy_e}, 32'd0);
        repeat (2) tick();
        check_val("abort_data_kept", {24'd0, data_e}, {24'd0, last_data});
        send_frame(8'h81, 1'b0, 0, 1'b0);

        // Odd-parity instance decisions on 0x01.
        send_frame(8'h01, 1'b0, 0, 1'b0);
        send_frame(8'h01, 1'b1, 0, 1'b0);

        // Saturation: 260 back-to-back even-parity errors.
        for (int k = 0; k < 260; k++) send_frame(8'h07, 1'b0, 0, 1'b0);
        tick();
        check_val("errc_saturated", {24'd0, errc_e}, 32'd255);

        // Reset mid-frame returns everything to zero on the next edge.
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_data", {24'd0, data_e}, 32'd0);
        check_val("mid_rst_perr", {31'd0, perr_e}, 32'd0);
        check_val("mid_rst_valid", {31'd0, ov_e}, 32'd0);
        check_val("mid_rst_busy", {31'd0, busy_e}, 32'd0);
        check_val("mid_rst_errc", {24'd0, errc_e}, 32'd0);
        check_val("mid_rst_errc_odd", {24'd0, errc_o}, 32'd0);
        rst = 1'b0;
        model_cnt_e = 0;
        model_cnt_o = 0;
        tick();
        send_frame(8'h5A, 1'b0, 0, 1'b0);
        repeat (4) tick();

        check_val("queue_even_drained", q_e.size(), 32'd0);
        check_val("queue_odd_drained", q_o.size(), 32'd0);
        check_val("pulse_count_even", pulses_e, pushed);
        check_val("pulse_count_odd", pulses_o, pushed);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
